// File: rtl/datapath_pkg.sv
// Shared datapath types for the ALU functional unit: opcodes, words and bus payloads.
package datapath_pkg;

    localparam int unsigned DP_WORD_W = 32;
    localparam int unsigned DP_TAG_W  = 5;

    typedef logic [DP_WORD_W-1:0] word_t;
    typedef logic [DP_TAG_W-1:0]  tag_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } aluop_t;

    typedef struct packed {
        aluop_t aluop;
        word_t  a;
        word_t  b;
        tag_t   rd;
    } fu_alu_req_t;

    typedef struct packed {
        word_t data;
        tag_t  rd;
        logic  neg;
        logic  ovf;
        logic  zero;
    } fu_alu_wb_t;

endpackage

// File: rtl/fu_wb_queue.sv
// In-order writeback FIFO of ALU results; flush empties it at the next edge.
module fu_wb_queue
    import datapath_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fu_alu_wb_t                   push_data_i,
    input  logic                         pop_i,
    output fu_alu_wb_t                   pop_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fu_alu_wb_t         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    // Pointer/count next state; flush wins over any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
            else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i && !rst_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == CNT_W'(0));
    assign count_o    = count_q;

endmodule

// File: rtl/fu_alu_issue.sv
// Issue-side driver for the combinational ALU: registers operands, queues results
// with their tags and hands them to writeback in issue order.
module fu_alu_issue
    import datapath_pkg::*;
#(
    parameter int unsigned WORD_W  = DP_WORD_W,
    parameter int unsigned TAG_W   = DP_TAG_W,
    parameter int unsigned Q_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        issue_aluop,
    input  logic [WORD_W-1:0] issue_a,
    input  logic [WORD_W-1:0] issue_b,
    input  logic [TAG_W-1:0]  issue_rd,
    output logic [3:0]        aluop,
    output logic [WORD_W-1:0] port_a,
    output logic [WORD_W-1:0] port_b,
    input  logic [WORD_W-1:0] port_output,
    input  logic              negative,
    input  logic              overflow,
    input  logic              zero,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [WORD_W-1:0] wb_data,
    output logic [TAG_W-1:0]  wb_rd,
    output logic              wb_neg,
    output logic              wb_ovf,
    output logic              wb_zero,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);

    fu_alu_req_t       s1_q, s1_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_adv;
    logic              issue_fire;
    logic              pop;
    logic              push;
    fu_alu_wb_t        wb_in;
    fu_alu_wb_t        wb_head;
    logic              q_full;
    logic              q_empty;
    logic [CNT_W-1:0]  q_count;

    assign pop         = wb_valid && wb_ready;
    assign s1_adv      = s1_valid_q && (!q_full || pop);
    assign issue_ready = !flush && (!s1_valid_q || s1_adv);
    assign issue_fire  = issue_valid && issue_ready;
    assign push        = s1_adv && !flush;

    // S1 next state; operands only change on a fire so the ALU inputs stay quiet.
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (issue_fire) begin
            s1_valid_d = 1'b1;
            s1_d.aluop = aluop_t'(issue_aluop);
            s1_d.a     = DP_WORD_W'(issue_a);
            s1_d.b     = DP_WORD_W'(issue_b);
            s1_d.rd    = DP_TAG_W'(issue_rd);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    assign aluop  = 4'(s1_q.aluop);
    assign port_a = WORD_W'(s1_q.a);
    assign port_b = WORD_W'(s1_q.b);

    always_comb begin
        wb_in      = '0;
        wb_in.data = DP_WORD_W'(port_output);
        wb_in.rd   = s1_q.rd;
        wb_in.neg  = negative;
        wb_in.ovf  = overflow;
        wb_in.zero = zero;
    end

    fu_wb_queue #(
        .DEPTH (Q_DEPTH)
    ) u_wb_queue (
        .clk_i       (CLK),
        .rst_i       (RST),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (wb_in),
        .pop_i       (pop),
        .pop_data_o  (wb_head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

    // Head entry drives writeback; zeros when nothing is queued.
    always_comb begin
        wb_valid = !q_empty;
        wb_data  = '0;
        wb_rd    = '0;
        wb_neg   = 1'b0;
        wb_ovf   = 1'b0;
        wb_zero  = 1'b0;
        if (!q_empty) begin
            wb_data = WORD_W'(wb_head.data);
            wb_rd   = TAG_W'(wb_head.rd);
            wb_neg  = wb_head.neg;
            wb_ovf  = wb_head.ovf;
            wb_zero = wb_head.zero;
        end
    end

    assign busy = s1_valid_q || (q_count != CNT_W'(0));

endmodule

// File: tb/tb_fu_alu_issue.sv
// Directed bench for fu_alu_issue with a behavioural ALU and a writeback scoreboard.
module tb_fu_alu_issue;
    import datapath_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, flush, issue_valid, issue_ready;
    logic [3:0]  issue_aluop, aluop;
    word_t       issue_a, issue_b, port_a, port_b, port_output, wb_data;
    tag_t        issue_rd, wb_rd;
    logic        negative, overflow, zero;
    logic        wb_valid, wb_ready, wb_neg, wb_ovf, wb_zero, busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    fu_alu_wb_t  sb [$];

    always #5 CLK = ~CLK;

    fu_alu_issue #(.WORD_W(32), .TAG_W(5), .Q_DEPTH(2)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_aluop(issue_aluop),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
        .aluop(aluop), .port_a(port_a), .port_b(port_b),
        .port_output(port_output), .negative(negative), .overflow(overflow), .zero(zero),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_neg(wb_neg), .wb_ovf(wb_ovf), .wb_zero(wb_zero), .busy(busy)
    );

    function automatic fu_alu_wb_t alu_ref(input aluop_t op, input word_t a, input word_t b,
                                           input tag_t rd);
        fu_alu_wb_t r;
        word_t      y;
        logic       v;
        v = 1'b0;
        case (op)
            ALU_ADD: begin y = a + b; v = (a[31] == b[31]) && (y[31] != a[31]); end
            ALU_SUB: begin y = a - b; v = (a[31] != b[31]) && (y[31] != a[31]); end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << b[4:0];
            ALU_SRL: y = a >> b[4:0];
            ALU_SRA: y = word_t'($signed(a) >>> b[4:0]);
            default: y = '0;
        endcase
        r.data = y;
        r.rd   = rd;
        r.neg  = y[31];
        r.ovf  = v;
        r.zero = (y == '0);
        return r;
    endfunction

    // Stand-in for the external combinational ALU.
    always_comb begin
        fu_alu_wb_t r;
        r           = alu_ref(aluop_t'(aluop), port_a, port_b, '0);
        port_output = r.data;
        negative    = r.neg;
        overflow    = r.ovf;
        zero        = r.zero;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accepted issue, compare on consumed writeback.
    always @(negedge CLK) begin : mon
        fu_alu_wb_t e;
        if (!RST && !flush) begin
            if (wb_valid && wb_ready) begin
                if (sb.size() == 0) begin
                    check("wb_spurious", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("sb_data", 64'(wb_data), 64'(e.data));
                    check("sb_rd",   64'(wb_rd),   64'(e.rd));
                    check("sb_neg",  64'(wb_neg),  64'(e.neg));
                    check("sb_ovf",  64'(wb_ovf),  64'(e.ovf));
                    check("sb_zero", 64'(wb_zero), 64'(e.zero));
                end
            end
            if (issue_valid && issue_ready)
                sb.push_back(alu_ref(aluop_t'(issue_aluop), issue_a, issue_b, issue_rd));
        end
    end

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic issue(input aluop_t op, input word_t a, input word_t b, input tag_t rd);
        issue_valid = 1'b1;
        issue_aluop = 4'(op);
        issue_a     = a;
        issue_b     = b;
        issue_rd    = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aluop_t ops [5];
        word_t  held_a;
        bit     drained;
        ops = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL};
        RST = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_aluop = '0;
        issue_a = '0; issue_b = '0; issue_rd = '0; wb_ready = 1'b0;
        repeat (3) next();
        sample();
        check("rst_wb_valid", 64'(wb_valid), 64'(0));
        check("rst_busy",     64'(busy),     64'(0));
        check("rst_port_a",   64'(port_a),   64'(0));
        check("rst_aluop",    64'(aluop),    64'(0));
        next(); RST = 1'b0;
        sample();
        check("rst_issue_ready", 64'(issue_ready), 64'(1));

        // Basic add, 2-cycle latency
        next(); issue(ALU_ADD, 32'd5, 32'd3, 5'd4); wb_ready = 1'b1;
        sample(); check("add_ready", 64'(issue_ready), 64'(1));
        next(); issue_valid = 1'b0;
        sample();
        check("add_c1_wbv",  64'(wb_valid), 64'(0));
        check("add_c1_busy", 64'(busy),     64'(1));
        check("add_c1_pa",   64'(port_a),   64'(5));
        check("add_c1_pb",   64'(port_b),   64'(3));
        next(); sample();
        check("add_wbv",  64'(wb_valid), 64'(1));
        check("add_data", 64'(wb_data),  64'(8));
        check("add_rd",   64'(wb_rd),    64'(4));
        check("add_flags", 64'({wb_neg, wb_ovf, wb_zero}), 64'(0));
        next(); sample();
        check("add_idle_wbv",  64'(wb_valid), 64'(0));
        check("add_idle_data", 64'(wb_data),  64'(0));
        check("add_idle_busy", 64'(busy),     64'(0));

        // Zero then overflow, back-to-back
        next(); issue(ALU_SUB, 32'd7, 32'd7, 5'd1); sample();
        next(); issue(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd2); sample();
        next(); issue_valid = 1'b0; sample();
        check("sub_rd",   64'(wb_rd),   64'(1));
        check("sub_data", 64'(wb_data), 64'(0));
        check("sub_zero", 64'(wb_zero), 64'(1));
        next(); sample();
        check("ovf_rd",    64'(wb_rd),   64'(2));
        check("ovf_data",  64'(wb_data), 64'h8000_0000);
        check("ovf_flags", 64'({wb_neg, wb_ovf, wb_zero}), 64'(3'b110));
        next(); sample();
        check("ovf_idle", 64'(wb_valid), 64'(0));

        // Backpressure: queue holds 1,2; S1 holds 3; 4 stalls
        wb_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            next(); issue(ALU_ADD, word_t'(k * 100), word_t'(k), tag_t'(k));
        end
        next(); issue(ALU_ADD, 32'd400, 32'd4, 5'd4); sample();
        check("bp_ready", 64'(issue_ready), 64'(0));
        check("bp_wbv",   64'(wb_valid),    64'(1));
        check("bp_rd",    64'(wb_rd),       64'(1));
        next(); sample();
        check("bp_hold_ready", 64'(issue_ready), 64'(0));
        check("bp_hold_rd",    64'(wb_rd),       64'(1));
        check("bp_hold_data",  64'(wb_data),     64'(101));
        next(); wb_ready = 1'b1; sample();
        check("bp_rel_ready", 64'(issue_ready), 64'(1));
        check("bp_rel_rd",    64'(wb_rd),       64'(1));
        for (int k = 2; k <= 4; k++) begin
            next(); issue_valid = 1'b0; sample();
            check("bp_drain_rd", 64'(wb_rd), 64'(k));
        end
        check("bp_last_data", 64'(wb_data), 64'(404));
        next(); sample();
        check("bp_empty", 64'(wb_valid), 64'(0));

        // Full queue with simultaneous push/pop
        wb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next(); issue(ops[k], $urandom, $urandom, tag_t'(10 + k));
        end
        for (int k = 3; k < 8; k++) begin
            next(); wb_ready = 1'b1;
            issue(ops[k % 5], $urandom, $urandom, tag_t'(10 + k));
            sample();
            check("full_ready", 64'(issue_ready),  64'(1));
            check("full_wbv",   64'(wb_valid),     64'(1));
            check("full_count", 64'(dut.q_count),  64'(2));
            check("full_rd",    64'(wb_rd),        64'(10 + k - 3));
        end
        next(); issue_valid = 1'b0;
        drained = 1'b0;
        for (int i = 0; i < 20 && !drained; i++) begin
            sample();
            if (!busy) drained = 1'b1;
            else next();
        end
        check("full_drained", 64'(drained),   64'(1));
        check("full_sb_empty", 64'(sb.size()), 64'(0));

        // Flush with S1 and both queue entries occupied
        wb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next(); issue(ALU_XOR, word_t'(32'h1000 + k), 32'h0F0F, tag_t'(20 + k));
        end
        held_a = 32'h1002;
        next(); flush = 1'b1; issue(ALU_ADD, 32'd1, 32'd1, 5'd23); sample();
        check("fl_ready", 64'(issue_ready), 64'(0));
        check("fl_busy",  64'(busy),        64'(1));
        next(); flush = 1'b0; issue_valid = 1'b0; sample();
        check("fl_busy_after", 64'(busy),     64'(0));
        check("fl_wbv_after",  64'(wb_valid), 64'(0));
        check("fl_rd_after",   64'(wb_rd),    64'(0));
        check("fl_port_a",     64'(port_a),   64'(held_a));
        sb.delete();
        next(); sample();
        check("fl_no_accept", 64'(busy), 64'(0));

        // Reset mid-operation, then a clean op
        for (int k = 0; k < 3; k++) begin
            next(); issue(ALU_OR, word_t'(k), 32'h50, tag_t'(30 + k));
        end
        next(); RST = 1'b1; issue_valid = 1'b0; sample();
        next(); RST = 1'b0; sample();
        check("mr_aluop", 64'(aluop),       64'(0));
        check("mr_pa",    64'(port_a),      64'(0));
        check("mr_pb",    64'(port_b),      64'(0));
        check("mr_wbv",   64'(wb_valid),    64'(0));
        check("mr_busy",  64'(busy),        64'(0));
        check("mr_ready", 64'(issue_ready), 64'(1));
        sb.delete();
        wb_ready = 1'b1;
        next(); issue(ALU_ADD, 32'd20, 32'd22, 5'd9); sample();
        next(); issue_valid = 1'b0; sample();
        check("mr_c1_wbv", 64'(wb_valid), 64'(0));
        next(); sample();
        check("mr_wbv2", 64'(wb_valid), 64'(1));
        check("mr_data", 64'(wb_data),  64'(42));
        check("mr_rd",   64'(wb_rd),    64'(9));
        next(); sample();
        check("mr_idle",     64'(busy),      64'(0));
        check("end_sb_size", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
